// File: rtl/md5_start_sequencer_if.sv
// ---------------------------------------------------------------------------
// md5_start_sequencer_if
//   Signal bundle between top-level control / the MD5 core array and the
//   start sequencer.
//   master : the sequencer (samples enable/core_done, drives core controls
//            and status)
//   slave  : the environment (drives enable/core_done, observes the rest)
//   Signals:
//     enable      run request, only its rising edge acts
//     core_done   per-channel done, level or pulse
//     core_reset  per-channel core reset, active-high
//     core_start  one-cycle start pulse, all bits together
//     busy        high from trigger until DONE/FAULT
//     all_done    high while in DONE
//     timeout     high while in FAULT
// ---------------------------------------------------------------------------
interface md5_start_sequencer_if #(
  parameter int N_CH = 4
);
  logic            enable;
  logic [N_CH-1:0] core_done;
  logic [N_CH-1:0] core_reset;
  logic [N_CH-1:0] core_start;
  logic            busy;
  logic            all_done;
  logic            timeout;

  modport master (
    input  enable, core_done,
    output core_reset, core_start, busy, all_done, timeout
  );

  modport slave (
    output enable, core_done,
    input  core_reset, core_start, busy, all_done, timeout
  );
endinterface

// File: rtl/md5_start_sequencer.sv
// ---------------------------------------------------------------------------
// md5_start_sequencer
//   Reset/start sequencer for N_CH MD5 core channels. A rising edge of
//   enable holds every core in reset for HOLD_CYCLES, releases the channel
//   resets one by one STAGGER_CYCLES apart, fires a common one-cycle start
//   pulse, then collects per-channel done until all are done (DONE) or
//   TIMEOUT_CYCLES of RUN elapse (FAULT). With REARM=1 a new enable edge in
//   DONE/FAULT starts another run.
//   Ports:
//     clock        module clock, rising edge
//     reset        asynchronous active-low system reset
//     bus          md5_start_sequencer_if.master (enable, core_done in;
//                  core_reset, core_start, busy, all_done, timeout out)
//     dbg_state_o  current FSM state encoding, for observation only
//   Handshake: there is no valid/ready pair. enable acts only on its rising
//   edge (sampled each clock against its registered copy) and only when the
//   FSM is idle or, with REARM=1, finished; core_done bits are sticky-latched
//   during RUN so a single-cycle pulse per channel is enough.
// ---------------------------------------------------------------------------
module md5_start_sequencer #(
  parameter int N_CH           = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int REARM          = 0
) (
  input  logic                        clock,
  input  logic                        reset,
  md5_start_sequencer_if.master       bus,
  output logic [2:0]                  dbg_state_o
);

  localparam int MAXV_HS = (HOLD_CYCLES > N_CH * STAGGER_CYCLES) ?
                           HOLD_CYCLES : N_CH * STAGGER_CYCLES;
  localparam int MAXV    = (MAXV_HS > TIMEOUT_CYCLES) ? MAXV_HS : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(MAXV + 1);

  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  // RELEASE offset one past the last channel's release: move to START here.
  localparam logic [CW-1:0] REL_LAST  = CW'((N_CH - 1) * STAGGER_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST   = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HOLD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_START   = 3'd3,
    ST_RUN     = 3'd4,
    ST_DONE    = 3'd5,
    ST_FAULT   = 3'd6
  } state_t;

  state_t          state_q;
  logic            enable_q;
  logic            ran_q;
  logic [CW-1:0]   cnt_q;
  logic [N_CH-1:0] done_lat_q;
  logic [N_CH-1:0] core_reset_q;
  logic [N_CH-1:0] core_start_q;
  logic            busy_q;
  logic            all_done_q;
  logic            timeout_q;

  logic            trigger_d;
  logic [N_CH-1:0] done_d;
  logic [CW-1:0]   rel_off_d;
  logic [N_CH-1:0] rel_mask_d;

  assign trigger_d = bus.enable & ~enable_q;
  // Includes this cycle's core_done so the last done moves to DONE next edge.
  assign done_d    = done_lat_q | bus.core_done;

  // Offset (in cycles) of the current edge from the edge leaving HOLD; the
  // HOLD exit edge itself is offset 0, which is when channel 0 is released.
  assign rel_off_d = (state_q == ST_RELEASE) ? cnt_q : '0;

  always_comb begin
    rel_mask_d = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (int'(rel_off_d) == k * STAGGER_CYCLES) rel_mask_d[k] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      enable_q     <= 1'b0;
      ran_q        <= 1'b0;
      cnt_q        <= '0;
      done_lat_q   <= '0;
      core_reset_q <= '1;
      core_start_q <= '0;
      busy_q       <= 1'b0;
      all_done_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      enable_q     <= bus.enable;
      core_start_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (trigger_d && (REARM != 0 || !ran_q)) begin
            state_q <= ST_HOLD;
            busy_q  <= 1'b1;
            ran_q   <= 1'b1;
            cnt_q   <= '0;
          end
        end
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_q      <= ST_RELEASE;
            core_reset_q <= core_reset_q & ~rel_mask_d;
            cnt_q        <= ONE;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
        ST_RELEASE: begin
          core_reset_q <= core_reset_q & ~rel_mask_d;
          if (cnt_q == REL_LAST) begin
            state_q      <= ST_START;
            core_start_q <= '1;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
        ST_START: begin
          // Clearing here discards any done seen during the start cycle.
          state_q    <= ST_RUN;
          done_lat_q <= '0;
          cnt_q      <= '0;
        end
        ST_RUN: begin
          if (&done_d) begin
            state_q    <= ST_DONE;
            done_lat_q <= done_d;
            all_done_q <= 1'b1;
            busy_q     <= 1'b0;
          end else if (TIMEOUT_CYCLES > 0 && cnt_q == TO_LAST) begin
            state_q      <= ST_FAULT;
            timeout_q    <= 1'b1;
            busy_q       <= 1'b0;
            core_reset_q <= '1;
          end else begin
            done_lat_q <= done_d;
            if (TIMEOUT_CYCLES > 0) cnt_q <= cnt_q + ONE;
          end
        end
        ST_DONE, ST_FAULT: begin
          if (trigger_d && REARM != 0) begin
            state_q      <= ST_HOLD;
            all_done_q   <= 1'b0;
            timeout_q    <= 1'b0;
            core_reset_q <= '1;
            done_lat_q   <= '0;
            busy_q       <= 1'b1;
            ran_q        <= 1'b1;
            cnt_q        <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.core_reset = core_reset_q;
  assign bus.core_start = core_start_q;
  assign bus.busy       = busy_q;
  assign bus.all_done   = all_done_q;
  assign bus.timeout    = timeout_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_md5_start_sequencer.sv
// ---------------------------------------------------------------------------
// tb_md5_start_sequencer
//   dut_a: N_CH=4 HOLD=16 STAGGER=2 TIMEOUT=0  REARM=0
//   dut_b: N_CH=4 HOLD=16 STAGGER=0 TIMEOUT=50 REARM=1
//   Expected behaviour comes from the run timeline: with the trigger edge as
//   j=0, channel k reset falls after edge HOLD+k*STAGGER, start is high after
//   edge HOLD+(N-1)*STAGGER+1, all_done follows the edge that samples the
//   last outstanding done, timeout follows the TIMEOUT-th RUN edge.
// ---------------------------------------------------------------------------
module tb_md5_start_sequencer;
  localparam int N    = 4;
  localparam int HOLD = 16;
  localparam logic [N-1:0] ALL = '1;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  md5_start_sequencer_if #(.N_CH(N)) if_a ();
  md5_start_sequencer_if #(.N_CH(N)) if_b ();
  logic [2:0] dbg_a, dbg_b;

  md5_start_sequencer #(.N_CH(N), .HOLD_CYCLES(HOLD), .STAGGER_CYCLES(2),
                        .TIMEOUT_CYCLES(0), .REARM(0)) dut_a (
    .clock(clock), .reset(reset), .bus(if_a), .dbg_state_o(dbg_a));

  md5_start_sequencer #(.N_CH(N), .HOLD_CYCLES(HOLD), .STAGGER_CYCLES(0),
                        .TIMEOUT_CYCLES(50), .REARM(1)) dut_b (
    .clock(clock), .reset(reset), .bus(if_b), .dbg_state_o(dbg_b));

  int n_checks = 0;
  int n_fail   = 0;
  int sel = 0;          // 0 observes/drives dut_a, 1 dut_b
  int cur_stagger = 2;
  int cur_timeout = 0;

  logic [N-1:0] o_rst, o_start;
  logic         o_busy, o_done, o_to;

  always_comb begin
    if (sel == 0) begin
      o_rst = if_a.core_reset; o_start = if_a.core_start;
      o_busy = if_a.busy; o_done = if_a.all_done; o_to = if_a.timeout;
    end else begin
      o_rst = if_b.core_reset; o_start = if_b.core_start;
      o_busy = if_b.busy; o_done = if_b.all_done; o_to = if_b.timeout;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_en(input logic v);
    if (sel == 0) if_a.enable = v; else if_b.enable = v;
  endtask

  task automatic set_done(input logic [N-1:0] v);
    if (sel == 0) if_a.core_done = v; else if_b.core_done = v;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Raise enable and follow the run up to the start cycle (or stop_j).
  task automatic seq_to_start(input int stop_j);
    int start_j;
    logic [N-1:0] er;
    logic es;
    start_j = HOLD + (N - 1) * cur_stagger + 1;
    set_en(1'b1);
    for (int j = 0; j <= start_j && j <= stop_j; j++) begin
      tick();
      for (int k = 0; k < N; k++) er[k] = (j >= HOLD + k * cur_stagger) ? 1'b0 : 1'b1;
      es = (j == start_j);
      n_checks++;
      if (o_rst !== er || o_start !== {N{es}} || o_busy !== 1'b1 ||
          o_done !== 1'b0 || o_to !== 1'b0) begin
        n_fail++;
        $display("FAIL seq dut=%0d j=%0d: got reset=%b start=%b busy=%b done=%b to=%b, want reset=%b start=%b busy=1 done=0 to=0",
                 sel, j, o_rst, o_start, o_busy, o_done, o_to, er, {N{es}});
      end
    end
  endtask

  // From the start cycle: pulse each channel's done at its RUN cycle
  // (-1 = never) and follow until DONE or FAULT.
  task automatic run_phase(input int t0, input int t1, input int t2, input int t3,
                           input bit done_in_start, input bit toggle_en);
    int tp[N];
    logic [N-1:0] seen, m;
    bit fin, exp_done, exp_to;
    int r;
    tp = '{t0, t1, t2, t3};
    seen = '0; fin = 1'b0; r = 0;
    if (done_in_start) set_done(ALL);
    tick();
    set_done('0);
    n_checks++;
    if (o_start !== '0 || o_done !== 1'b0 || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_exit dut=%0d: got start=%b done=%b busy=%b, want start=0 done=0 busy=1",
               sel, o_start, o_done, o_busy);
    end
    while (!fin && r < 200) begin
      m = '0;
      for (int k = 0; k < N; k++) if (tp[k] == r) m[k] = 1'b1;
      set_done(m);
      if (toggle_en && r == 0) set_en(1'b0);
      if (toggle_en && r == 2) set_en(1'b1);
      tick();
      seen     = seen | m;
      exp_done = (seen == ALL);
      exp_to   = !exp_done && cur_timeout > 0 && r == cur_timeout - 1;
      fin      = exp_done || exp_to;
      n_checks++;
      if (o_done !== exp_done || o_to !== exp_to || o_busy !== !fin ||
          o_start !== '0 || o_rst !== (exp_to ? ALL : '0)) begin
        n_fail++;
        $display("FAIL run dut=%0d r=%0d: got done=%b to=%b busy=%b start=%b reset=%b, want done=%b to=%b busy=%b start=0 reset=%b",
                 sel, r, o_done, o_to, o_busy, o_start, o_rst, exp_done, exp_to, !fin,
                 exp_to ? ALL : '0);
      end
      r++;
    end
    set_done('0);
    if (!fin) begin
      n_checks++;
      n_fail++;
      $display("FAIL run_bound dut=%0d: run did not finish within %0d cycles", sel, r);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    if_a.enable = 1'b0; if_a.core_done = '0;
    if_b.enable = 1'b0; if_b.core_done = '0;
    reset = 1'b0;
    repeat (2) tick();
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      n_checks++;
      if (o_rst !== ALL || o_start !== '0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_to !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_values dut=%0d: got reset=%b start=%b busy=%b done=%b to=%b, want 1111 0000 0 0 0",
                 s, o_rst, o_start, o_busy, o_done, o_to);
      end
    end
    reset = 1'b1;
    repeat (3) tick();
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      n_checks++;
      if (o_rst !== ALL || o_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_no_enable dut=%0d: got reset=%b busy=%b, want 1111 0", s, o_rst, o_busy);
      end
    end
  endtask

  task automatic test_basic_run();
    sel = 0; cur_stagger = 2; cur_timeout = 0;
    #1;
    seq_to_start(1000);
    // done pulses in order ch2, ch0, ch3, ch1; enable toggled while busy
    run_phase(3, 9, 1, 5, 1'b0, 1'b1);
    // second enable edge is ignored with REARM=0
    set_en(1'b0);
    tick();
    set_en(1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (o_done !== 1'b1 || o_busy !== 1'b0 || o_rst !== '0 || o_to !== 1'b0) begin
        n_fail++;
        $display("FAIL no_rearm i=%0d: got done=%b busy=%b reset=%b to=%b, want 1 0 0000 0",
                 i, o_done, o_busy, o_rst, o_to);
      end
    end
  endtask

  task automatic test_reset_mid_release();
    sel = 0; cur_stagger = 2; cur_timeout = 0;
    set_en(1'b0);
    reset = 1'b0;
    #1;
    reset = 1'b1;
    tick();
    // stop after channels 0 and 1 are released
    seq_to_start(HOLD + cur_stagger + 1);
    reset = 1'b0;
    #1;
    n_checks++;
    if (o_rst !== ALL || o_busy !== 1'b0 || o_start !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got reset=%b busy=%b start=%b, want 1111 0 0000", o_rst, o_busy, o_start);
    end
    #2;
    reset = 1'b1;   // enable still high: first edge re-triggers
    seq_to_start(1000);
    run_phase($urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 20),
              $urandom_range(0, 20), 1'b0, 1'b0);
  endtask

  task automatic test_stagger0_timeout();
    sel = 1; cur_stagger = 0; cur_timeout = 50;
    #1;
    seq_to_start(1000);
    run_phase($urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 40),
              -1, 1'b0, 1'b0);
  endtask

  task automatic test_rearm_repeat();
    sel = 1; cur_stagger = 0; cur_timeout = 50;
    for (int it = 0; it < 3; it++) begin
      set_en(1'b0);
      tick();
      seq_to_start(1000);
      run_phase($urandom_range(1, 30), $urandom_range(1, 30), $urandom_range(1, 30),
                $urandom_range(1, 30), it == 1, 1'b0);
    end
  endtask

  // ---------------- main + report ----------------
  initial begin
    test_reset();
    test_basic_run();
    test_reset_mid_release();
    test_stagger0_timeout();
    test_rearm_repeat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
